// File: rtl/rx78_keyboard.sv
// RX-78 keyboard responder on I/O port F4: a PS/2 frame receiver feeds a scancode
// decoder that maintains the key matrix, and the CPU reads one strobed row per access.
module rx78_keyboard #(
  parameter int          ROWS    = 9,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_en,
  input  logic [7:0] io_addr,
  input  logic       io_wr_n,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       io_hit,
  input  logic       ps2_clk,
  input  logic       ps2_data
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_t;

  // ---------------------------------------------------------------------------
  // PS/2 synchronisers and falling-edge filter
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic [3:0] clk_hist_q, clk_hist_d;
  logic       ps2_fall;
  logic       ps2_dat;

  // NOTE: always_comb blocks assign every output first, so no path can infer a latch.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_hist_d = {clk_hist_q[2:0], clk_sync_q[1]};
  end

  // A glitch on the cable cannot fake an edge: four clean high samples must precede the low.
  assign ps2_fall = (clk_hist_q == 4'b1111) && !clk_sync_q[1];
  assign ps2_dat  = dat_sync_q[1];

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b00;
      dat_sync_q <= 2'b00;
      clk_hist_q <= 4'b0000;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_hist_q <= clk_hist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver: start, 8 data bits LSB first, odd parity, stop
  // ---------------------------------------------------------------------------
  rx_state_e   rx_state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        parity_q;
  logic [15:0] tmo_q;
  logic        byte_valid_q;
  logic        rx_err_q;
  logic [7:0]  rx_byte_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_q        <= 16'd0;
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_byte_q    <= 8'h00;
    end else begin
      byte_valid_q <= 1'b0;
      rx_err_q     <= 1'b0;
      if (ps2_fall) begin
        tmo_q <= 16'd0;
        case (rx_state_q)
          RX_IDLE: begin
            if (!ps2_dat) begin
              rx_state_q <= RX_DATA;
              bit_cnt_q  <= 3'd0;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q   <= {ps2_dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) rx_state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            parity_q   <= ps2_dat;
            rx_state_q <= RX_STOP;
          end
          RX_STOP: begin
            rx_state_q <= RX_IDLE;
            if (ps2_dat && (^{parity_q, shift_q})) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end else begin
              rx_err_q <= 1'b1;
            end
          end
          default: rx_state_q <= RX_IDLE;
        endcase
      end else if (rx_state_q != RX_IDLE) begin
        if (tmo_q == TIMEOUT - 16'd1) begin
          rx_state_q <= RX_IDLE;
          tmo_q      <= 16'd0;
          rx_err_q   <= 1'b1;
        end else begin
          tmo_q <= tmo_q + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scancode (set 2) to RX-78 matrix position
  // ---------------------------------------------------------------------------
  function automatic key_t map_key(input logic ext, input logic [7:0] code);
    key_t k;
    k = '0;
    case ({ext, code})
      9'h045: k = '{1'b1, 4'd0, 3'd0};
      9'h016: k = '{1'b1, 4'd0, 3'd1};
      9'h01E: k = '{1'b1, 4'd0, 3'd2};
      9'h026: k = '{1'b1, 4'd0, 3'd3};
      9'h025: k = '{1'b1, 4'd0, 3'd4};
      9'h02E: k = '{1'b1, 4'd0, 3'd5};
      9'h036: k = '{1'b1, 4'd0, 3'd6};
      9'h03D: k = '{1'b1, 4'd0, 3'd7};
      9'h03E: k = '{1'b1, 4'd1, 3'd0};
      9'h046: k = '{1'b1, 4'd1, 3'd1};
      9'h04C: k = '{1'b1, 4'd1, 3'd2};
      9'h052: k = '{1'b1, 4'd1, 3'd3};
      9'h041: k = '{1'b1, 4'd1, 3'd4};
      9'h04E: k = '{1'b1, 4'd1, 3'd5};
      9'h049: k = '{1'b1, 4'd1, 3'd6};
      9'h04A: k = '{1'b1, 4'd1, 3'd7};
      9'h054: k = '{1'b1, 4'd2, 3'd0};
      9'h01C: k = '{1'b1, 4'd2, 3'd1};
      9'h032: k = '{1'b1, 4'd2, 3'd2};
      9'h021: k = '{1'b1, 4'd2, 3'd3};
      9'h023: k = '{1'b1, 4'd2, 3'd4};
      9'h024: k = '{1'b1, 4'd2, 3'd5};
      9'h02B: k = '{1'b1, 4'd2, 3'd6};
      9'h034: k = '{1'b1, 4'd2, 3'd7};
      9'h033: k = '{1'b1, 4'd3, 3'd0};
      9'h043: k = '{1'b1, 4'd3, 3'd1};
      9'h03B: k = '{1'b1, 4'd3, 3'd2};
      9'h042: k = '{1'b1, 4'd3, 3'd3};
      9'h04B: k = '{1'b1, 4'd3, 3'd4};
      9'h03A: k = '{1'b1, 4'd3, 3'd5};
      9'h031: k = '{1'b1, 4'd3, 3'd6};
      9'h044: k = '{1'b1, 4'd3, 3'd7};
      9'h04D: k = '{1'b1, 4'd4, 3'd0};
      9'h015: k = '{1'b1, 4'd4, 3'd1};
      9'h02D: k = '{1'b1, 4'd4, 3'd2};
      9'h01B: k = '{1'b1, 4'd4, 3'd3};
      9'h02C: k = '{1'b1, 4'd4, 3'd4};
      9'h03C: k = '{1'b1, 4'd4, 3'd5};
      9'h02A: k = '{1'b1, 4'd4, 3'd6};
      9'h01D: k = '{1'b1, 4'd4, 3'd7};
      9'h022: k = '{1'b1, 4'd5, 3'd0};
      9'h035: k = '{1'b1, 4'd5, 3'd1};
      9'h01A: k = '{1'b1, 4'd5, 3'd2};
      9'h05B: k = '{1'b1, 4'd5, 3'd3};
      9'h05D: k = '{1'b1, 4'd5, 3'd4};
      9'h055: k = '{1'b1, 4'd5, 3'd5};
      9'h00E: k = '{1'b1, 4'd5, 3'd6};
      9'h066: k = '{1'b1, 4'd5, 3'd7};
      9'h05A: k = '{1'b1, 4'd6, 3'd0};
      9'h16B: k = '{1'b1, 4'd6, 3'd1};
      9'h174: k = '{1'b1, 4'd6, 3'd2};
      9'h172: k = '{1'b1, 4'd6, 3'd3};
      9'h170: k = '{1'b1, 4'd6, 3'd4};
      9'h171: k = '{1'b1, 4'd6, 3'd5};
      9'h16C: k = '{1'b1, 4'd6, 3'd6};
      9'h00D: k = '{1'b1, 4'd6, 3'd7};
      9'h029: k = '{1'b1, 4'd7, 3'd0};
      9'h076: k = '{1'b1, 4'd7, 3'd1};
      9'h014: k = '{1'b1, 4'd7, 3'd2};
      9'h169: k = '{1'b1, 4'd7, 3'd3};
      9'h005: k = '{1'b1, 4'd7, 3'd4};
      9'h006: k = '{1'b1, 4'd7, 3'd5};
      9'h004: k = '{1'b1, 4'd7, 3'd6};
      9'h00C: k = '{1'b1, 4'd7, 3'd7};
      9'h012: k = '{1'b1, 4'd8, 3'd0};
      9'h175: k = '{1'b1, 4'd8, 3'd1};
      9'h059: k = '{1'b1, 4'd8, 3'd2};
      9'h058: k = '{1'b1, 4'd8, 3'd3};
      9'h011: k = '{1'b1, 4'd8, 3'd4};
      default: k = '0;
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Decoder: E0/F0 prefixes, then make/break into the matrix
  // ---------------------------------------------------------------------------
  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic [ROWS-1:0][7:0] matrix_q, matrix_d;
  key_t                 key;

  assign key = map_key(ext_q, rx_byte_q);

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    matrix_d = matrix_q;
    if (rx_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
          if (key.hit && key.row == 4'(r)) matrix_d[r][key.col] = !brk_q;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CPU port F4
  // ---------------------------------------------------------------------------
  logic [3:0] strobe_q, strobe_d;
  logic [7:0] io_dout_q, io_dout_d;
  logic       io_hit_q, io_hit_d;
  logic       f4_sel;
  logic       unused_din;

  assign f4_sel     = io_en && (io_addr == 8'hF4);
  assign unused_din = &{1'b0, io_din[7:4]};

  // Reads see matrix_q, so a same-cycle key update lands only on the following read.
  always_comb begin
    strobe_d  = strobe_q;
    io_dout_d = 8'h00;
    io_hit_d  = 1'b0;
    if (f4_sel && !io_wr_n) strobe_d = io_din[3:0];
    if (f4_sel && io_wr_n) begin
      io_hit_d = 1'b1;
      for (int r = 0; r < ROWS; r++) begin
        if (strobe_q == 4'(r)) io_dout_d = matrix_q[r];
      end
    end
  end

  // NOTE: the key matrix is CPU-visible state, so it is flop-based and cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      matrix_q  <= '0;
      strobe_q  <= 4'd0;
      io_dout_q <= 8'h00;
      io_hit_q  <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      matrix_q  <= matrix_d;
      strobe_q  <= strobe_d;
      io_dout_q <= io_dout_d;
      io_hit_q  <= io_hit_d;
    end
  end

  assign io_dout = io_dout_q;
  assign io_hit  = io_hit_q;

endmodule

// File: tb/tb_rx78_keyboard.sv
// Self-checking bench for rx78_keyboard: directed scenarios plus random key traffic
// compared against a key-event model of the matrix.
module tb_rx78_keyboard;

  localparam int          ROWS    = 9;
  localparam logic [15:0] TIMEOUT = 16'd20000;

  logic       clk;
  logic       reset;
  logic       io_en;
  logic [7:0] io_addr;
  logic       io_wr_n;
  logic [7:0] io_din;
  logic [7:0] io_dout;
  logic       io_hit;
  logic       ps2_clk;
  logic       ps2_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: matrix rows (rows beyond ROWS stay zero) and prefix flags
  logic [7:0] mdl [16];
  bit         mdl_ext;
  bit         mdl_brk;

  rx78_keyboard #(.ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .reset   (reset),
    .io_en   (io_en),
    .io_addr (io_addr),
    .io_wr_n (io_wr_n),
    .io_din  (io_din),
    .io_dout (io_dout),
    .io_hit  (io_hit),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Key table from the RX-78 layout: returns row*8+col, or -1 when the key is not mapped.
  function automatic int key_pos(input bit ext, input logic [7:0] code);
    if (!ext) begin
      case (code)
        8'h16: return 0 * 8 + 1;
        8'h1C: return 2 * 8 + 1;
        8'h5A: return 6 * 8 + 0;
        8'h29: return 7 * 8 + 0;
        8'h12: return 8 * 8 + 0;
        default: return -1;
      endcase
    end else begin
      case (code)
        8'h75: return 8 * 8 + 1;
        default: return -1;
      endcase
    end
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 16; r++) mdl[r] = 8'h00;
    mdl_ext = 0;
    mdl_brk = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int p;
    if (b == 8'hE0) mdl_ext = 1;
    else if (b == 8'hF0) mdl_brk = 1;
    else begin
      p = key_pos(mdl_ext, b);
      if (p >= 0) mdl[p / 8][p % 8] = !mdl_brk;
      mdl_ext = 0;
      mdl_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sends the first nbits of a well-formed frame carrying b.
  task automatic send_bits(input logic [7:0] b, input bit bad_parity, input int nbits);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(frame[i]);
    ps2_data = 1'b1;
  endtask

  // Full frame plus model update; a corrupted frame only clears the prefix flags.
  task automatic tx(input logic [7:0] b, input bit bad_parity);
    send_bits(b, bad_parity, 11);
    repeat (20) @(negedge clk);
    if (bad_parity) begin
      mdl_ext = 0;
      mdl_brk = 0;
    end else begin
      model_byte(b);
    end
  endtask

  task automatic wr_f4(input logic [7:0] d);
    @(negedge clk);
    io_en   = 1'b1;
    io_addr = 8'hF4;
    io_wr_n = 1'b0;
    io_din  = d;
    @(negedge clk);
    io_en   = 1'b0;
    io_addr = 8'h00;
    io_wr_n = 1'b1;
    io_din  = 8'h00;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [7:0] exp_d, input logic exp_h,
                    input string tag);
    @(negedge clk);
    io_en   = 1'b1;
    io_addr = addr;
    io_wr_n = 1'b1;
    @(negedge clk);
    io_en   = 1'b0;
    io_addr = 8'h00;
    check({tag, " dout"}, io_dout, exp_d);
    check({tag, " hit"}, io_hit, exp_h);
  endtask

  logic [7:0] keys_code [10] = '{8'h1C, 8'h5A, 8'h29, 8'h12, 8'h16,
                                 8'h75, 8'h75, 8'h1C, 8'hAA, 8'hFA};
  bit         keys_ext  [10] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};

  initial begin
    reset    = 1'b1;
    io_en    = 1'b0;
    io_addr  = 8'h00;
    io_wr_n  = 1'b1;
    io_din   = 8'h00;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset dout", io_dout, 8'h00);
    check("reset hit", io_hit, 1'b0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Make code 1C lands on row 2 bit 1; hit drops once the read ends
    tx(8'h1C, 0);
    wr_f4(8'h02);
    rd(8'hF4, 8'h02, 1'b1, "make 1C row2");
    @(negedge clk);
    check("hit after read", io_hit, 1'b0);
    check("dout after read", io_dout, 8'h00);

    tx(8'hF0, 0);
    tx(8'h1C, 0);
    rd(8'hF4, 8'h00, 1'b1, "break 1C row2");

    tx(8'hE0, 0);
    tx(8'h75, 0);
    wr_f4(8'h08);
    rd(8'hF4, 8'h02, 1'b1, "E0 75 row8");
    tx(8'h12, 0);
    rd(8'hF4, 8'h03, 1'b1, "12 row8");

    // Bad parity is dropped, the retry is accepted
    tx(8'h5A, 1);
    wr_f4(8'h06);
    rd(8'hF4, 8'h00, 1'b1, "bad parity 5A");
    tx(8'h5A, 0);
    rd(8'hF4, 8'h01, 1'b1, "good 5A");

    // Abandoned partial frame must not corrupt the next byte
    send_bits(8'h29, 0, 6);
    repeat (int'(TIMEOUT) + 50) @(negedge clk);
    tx(8'h29, 0);
    wr_f4(8'h07);
    rd(8'hF4, 8'h01, 1'b1, "29 after timeout");

    wr_f4(8'h0C);
    rd(8'hF4, 8'h00, 1'b1, "strobe 0C");
    rd(8'hF5, 8'h00, 1'b0, "port F5");

    // Reset with a key held and a frame in flight
    tx(8'h16, 0);
    send_bits(8'h5A, 0, 4);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    repeat (10) @(negedge clk);
    rd(8'hF4, 8'h00, 1'b1, "post-reset row0");
    tx(8'h16, 0);
    rd(8'hF4, 8'h02, 1'b1, "16 after reset, strobe 0");
    for (int r = 1; r < ROWS; r++) begin
      wr_f4(8'(r));
      rd(8'hF4, mdl[r], 1'b1, $sformatf("post-reset row%0d", r));
    end

    // Random key traffic against the model
    for (int it = 0; it < 30; it++) begin
      int         k;
      bit         brk;
      logic [3:0] s;
      k   = int'($urandom_range(0, 9));
      brk = 1'($urandom_range(0, 1));
      if (keys_ext[k]) tx(8'hE0, $urandom_range(0, 9) == 0);
      if (brk) tx(8'hF0, $urandom_range(0, 9) == 0);
      tx(keys_code[k], $urandom_range(0, 9) == 0);
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s = 4'($urandom_range(0, ROWS - 1));
      wr_f4({4'($urandom_range(0, 15)), s});
      rd(8'hF4, mdl[s], 1'b1, $sformatf("rand %0d row%0d", it, s));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx78_keyboard.md
Name: rx78_keyboard

Overview:
- Z80 I/O responder that returns RX-78 keyboard matrix state on port F4.
- The CPU writes a row strobe to port F4, then reads F4 back to get that row's column bits.
- Matrix state comes from a PS/2 keyboard through an internal frame receiver and a scancode-to-matrix decoder.
- Sits beside the existing I/O decode; the top ORs `io_dout` into the I/O read mux when `io_hit` is high.

Parameters:
- ROWS, 9, number of implemented matrix rows (row indices 0..ROWS-1).
- TIMEOUT, 16'd20000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.

Ports:
- clk  in  1  system clock (CPU clock domain).
- reset  in  1  asynchronous, active-high reset.
- io_en  in  1  I/O cycle active (iorq low and m1 high, already decoded by the top).
- io_addr  in  8  low byte of the CPU address.
- io_wr_n  in  1  CPU write strobe, active low.
- io_din  in  8  CPU data out.
- io_dout  out  8  read data for port F4.
- io_hit  out  1  high while `io_dout` is valid for the current I/O read.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.

Behaviour:
- Reset (async, active-high), all cleared: `io_dout`=00, `io_hit`=0, strobe=0, matrix all 0, receiver IDLE, E0/F0 flags 0, timeout counter 0.
- Synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flops.
- Edge filter: a falling edge is accepted only after the synced clock has read 1 on 4 consecutive samples and then 0.
- Receiver FSM, one data bit per accepted falling edge:
  - IDLE: data=0 goes to DATA; data=1 stays in IDLE (bad start bit).
  - DATA: shifts 8 bits LSB-first, then goes to PARITY.
  - PARITY: captures the parity bit, goes to STOP.
  - STOP: goes to IDLE. The byte is delivered (one-cycle `byte_valid`) only if stop=1 and the 9 bits have odd parity.
  - On any error the byte is dropped and the E0/F0 flags are cleared.
- Timeout: counter increments in any non-IDLE state and resets on each accepted edge. At TIMEOUT-1 the FSM returns to IDLE with no byte delivered.
- Decoder, acting on `byte_valid`:
  - E0: set the extended flag.
  - F0: set the break flag.
  - Any other byte: look up (extended, code), then clear both flags.
  - Mapped key: set matrix[row][col] on make, clear it on break.
  - Unmapped codes (including AA and FA): ignored, flags still cleared.
- Required table entries (full table held in the same case statement):
  - 1C -> r2 b1
  - 5A -> r6 b0
  - 29 -> r7 b0
  - 12 -> r8 b0
  - E0 75 -> r8 b1
  - 16 -> r0 b1
- Port F4 write (io_en & io_addr==F4 & !io_wr_n): strobe <= io_din[3:0], takes effect the next cycle.
- Port F4 read (io_en & io_addr==F4 & io_wr_n):
  - Registered response, one cycle of latency: `io_dout` <= matrix[strobe]; `io_hit` <= 1.
  - If strobe >= ROWS, `io_dout` <= 00.
- Any other cycle: `io_dout` <= 00 and `io_hit` <= 0.
- Bit polarity: pressed key = 1.
- Simultaneous matrix update and F4 read in the same cycle: the read returns the pre-update row value.
- Reset mid-frame: the partial frame is discarded; receiving resumes on the next start bit.

Test Plan:
- PS/2 frame 1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1); write F4=02; read F4 -> `io_dout`=02 and `io_hit`=1 one cycle after the read.
- Send F0 1C; read row 2 -> 00. Send E0 75; read row 8 -> 02. Send 12 as well; row 8 -> 03.
- Frame 5A with parity flipped -> matrix unchanged; row 6 reads 00. A following valid 5A -> row 6 reads 01.
- Send 6 bits of a frame, idle for TIMEOUT clocks, then a full 29 frame -> row 7 reads 01 (no corruption from the partial frame).
- Write F4=0C; read -> 00 with `io_hit`=1. Read port F5 -> `io_hit`=0.
- Assert reset while 16 is held and mid-frame -> all rows read 00 and strobe=0. A subsequent 16 frame -> row 0 reads 02.
